parking_occupancy_ctrl: RTL and testbench
=========================================

Name: parking_occupancy_ctrl

Overview:
- Sequential requester side of the lot's 8-bit add/subtract datapath.
- Accepts entry and exit events from the gate sensors over a req/ack handshake.
- Sequences one increment or decrement of the occupancy count per event, and reports count, free spaces, full/empty and error status to the display and gate logic.

Parameters:
CAPACITY, 8'd200, number of parking spaces; legal range 1..255
WIDTH, 8, count/datapath width; fixed at 8 for this release

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
entry_req  input  1  entry gate requests admission; held high until entry_ack
exit_req  input  1  exit gate reports a departing car; held high until exit_ack
entry_ack  output  1  one-cycle pulse completing an entry request
entry_grant  output  1  valid with entry_ack: 1 = admitted, 0 = rejected because lot full
exit_ack  output  1  one-cycle pulse completing an exit request
count  output  8  current occupancy
free  output  8  CAPACITY - count, registered
full  output  1  count == CAPACITY
empty  output  1  count == 0
err_underflow  output  1  sticky; exit seen while empty; cleared only by reset

Behaviour:
- Reset (async assert, sync release):
  - count=0, free=CAPACITY, full=0, empty=1.
  - entry_ack=0, entry_grant=0, exit_ack=0, err_underflow=0.
  - FSM in IDLE; both arm flags set.
- FSM states: IDLE, COMPUTE, RESPOND.
- IDLE:
  - exit_req && exit_arm -> latch op=SUB, go COMPUTE.
  - Otherwise entry_req && entry_arm -> latch op=ADD, go COMPUTE.
  - Exit has priority on simultaneous requests because it frees a space. The pending entry is served on the next IDLE visit.
- COMPUTE: datapath evaluates count ± 1 (A=count, B=8'd1, sel=1 for SUB); operand and result are registered. Go RESPOND.
- RESPOND:
  - Assert the matching ack for exactly one cycle.
  - On the same edge, update count, free, full and empty.
  - Clear the matching arm flag, then return to IDLE.
- Latency: request sampled in IDLE at edge N; ack high in cycle N+2; new count visible from N+3. Throughput is one event per 3 cycles.
- Handshake (4-phase): an arm flag re-sets only when its req is sampled low. A req held high after its ack is never counted twice.
- Entry when count==CAPACITY: entry_ack=1, entry_grant=0, count unchanged.
- Exit when count==0: exit_ack=1, err_underflow set (sticky), count unchanged.
- Wrap-around never occurs: the full/empty guards are evaluated in IDLE before COMPUTE. The datapath carry-out is ignored except as an assertion check (ADD carry or SUB borrow must never fire).
- A req dropped before its ack (protocol violation) does not abort an operation already latched in COMPUTE/RESPOND; the operation completes.
- Reset mid-operation aborts immediately; no ack is issued.
- free, full and empty are always consistent with count in the same cycle.

Decomposition:
- Shared package parking_pkg:
  - FSM state encoding (IDLE=2'd0, COMPUTE=2'd1, RESPOND=2'd2).
  - OP_ADD/OP_SUB select constants.
  - Default CAPACITY constant, reused by the display and gate blocks.
- Sub-module occ_addsub: an 8-bit ripple add/subtract datapath (inputs A, B, sel; outputs S, cout), instantiated once for count ± 1.
- Second sub-module not needed: free is computed by a separate subtract of count from CAPACITY in this module. Alternatively it is a second occ_addsub instance with sel=1.

Test Plan:
- Reset, then 3 entry handshakes -> entry_ack with entry_grant=1 at N+2 each; count 1,2,3; free 197; empty=0.
- CAPACITY=2, 3 entries -> third entry_ack has entry_grant=0; count stays 2; full=1; free=0.
- From count=0, one exit -> exit_ack pulses; count stays 0; err_underflow=1 and remains 1 after a later entry.
- count=5, entry_req and exit_req rise in the same cycle -> exit_ack first (count 4), then entry_ack 3 cycles later (count 5); never both acks in one cycle.
- entry_req held high for 10 cycles after its ack -> exactly one increment; a second increment only after entry_req goes low then high.
- rst_n pulsed low while in COMPUTE with count=7 -> no ack; count=0, free=CAPACITY, empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/parking_occupancy_ctrl_pkg.sv
// Shared definitions for the parking lot occupancy controller and the
// display/gate blocks that consume its status.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int          DATA_W           = 8;
    localparam logic [7:0]  CAPACITY_DEFAULT = 8'd200;

endpackage

// File: rtl/parking_occupancy_ctrl_addsub.sv
// Ripple-carry add/subtract: S = A + B (sel=0) or A - B (sel=1).
// For subtraction cout=1 means no borrow.
module occ_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sel,
    output logic [WIDTH-1:0] S,
    output logic             cout
);

    logic [WIDTH-1:0] w_b;
    logic             w_c;

    assign w_b = B ^ {WIDTH{sel}};

    always_comb begin
        S   = '0;
        w_c = sel;
        for (int i = 0; i < WIDTH; i++) begin
            S[i] = A[i] ^ w_b[i] ^ w_c;
            w_c  = (A[i] & w_b[i]) | (w_c & (A[i] ^ w_b[i]));
        end
        cout = w_c;
    end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Occupancy controller: serves gate entry/exit requests one at a time over a
// 4-phase req/ack handshake and keeps count/free/full/empty coherent.
//
//   state   | meaning
//   IDLE    | wait for an armed request (exit wins over entry)
//   COMPUTE | datapath evaluates count +/- 1, result registered
//   RESPOND | ack pulse; count and status flags update on the closing edge
module parking_occupancy_ctrl
    import parking_pkg::*;
#(
    parameter int               WIDTH    = DATA_W,
    parameter logic [WIDTH-1:0] CAPACITY = CAPACITY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_req,
    input  logic             exit_req,
    output logic             entry_ack,
    output logic             entry_grant,
    output logic             exit_ack,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] free,
    output logic             full,
    output logic             empty,
    output logic             err_underflow
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_op;
    logic             r_reject;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_free;
    logic             r_full;
    logic             r_empty;
    logic             r_err;
    logic             r_entry_arm;
    logic             r_exit_arm;

    logic             w_take_exit;
    logic             w_take_entry;
    logic             w_guard;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_free;
    logic             w_free_cout;

    assign w_take_exit  = exit_req && r_exit_arm;
    assign w_take_entry = !w_take_exit && entry_req && r_entry_arm;
    // A guarded (rejected) operation runs through the datapath with B=0,
    // so the result is simply the unchanged count.
    assign w_guard      = w_take_exit ? r_empty : r_full;

    occ_addsub #(.WIDTH(WIDTH)) u_step (
        .A    (r_count),
        .B    (r_b),
        .sel  (r_op),
        .S    (w_sum),
        .cout (w_cout)
    );

    occ_addsub #(.WIDTH(WIDTH)) u_free (
        .A    (CAPACITY),
        .B    (r_result),
        .sel  (OP_SUB),
        .S    (w_free),
        .cout (w_free_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_take_exit || w_take_entry) w_state_nxt = COMPUTE;
            COMPUTE: w_state_nxt = RESPOND;
            RESPOND: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        entry_ack   = 1'b0;
        entry_grant = 1'b0;
        exit_ack    = 1'b0;
        if (r_state == RESPOND) begin
            if (r_op == OP_ADD) begin
                entry_ack   = 1'b1;
                entry_grant = !r_reject;
            end else begin
                exit_ack    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_ADD;
            r_reject <= 1'b0;
            r_b      <= '0;
            r_result <= '0;
            r_count  <= '0;
            r_free   <= CAPACITY;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take_exit || w_take_entry) begin
                        r_op     <= w_take_exit ? OP_SUB : OP_ADD;
                        r_reject <= w_guard;
                        r_b      <= w_guard ? '0 : WIDTH'(1);
                    end
                end
                COMPUTE: begin
                    r_result <= w_sum;
                    // add must not carry, subtract must not borrow
                    assert (w_cout == r_op);
                end
                RESPOND: begin
                    r_count <= r_result;
                    r_free  <= w_free;
                    r_full  <= (r_result == CAPACITY);
                    r_empty <= (r_result == '0);
                    if (r_op == OP_SUB && r_reject) r_err <= 1'b1;
                    assert (w_free_cout);
                end
                default: ;
            endcase
        end
    end

    // Clearing on the serving edge wins; re-arm needs the req seen low later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry_arm <= 1'b1;
            r_exit_arm  <= 1'b1;
        end else begin
            if (r_state == RESPOND && r_op == OP_ADD) r_entry_arm <= 1'b0;
            else if (!entry_req)                      r_entry_arm <= 1'b1;
            if (r_state == RESPOND && r_op == OP_SUB) r_exit_arm  <= 1'b0;
            else if (!exit_req)                       r_exit_arm  <= 1'b1;
        end
    end

    assign count         = r_count;
    assign free          = r_free;
    assign full          = r_full;
    assign empty         = r_empty;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Bench for parking_occupancy_ctrl: two instances (capacity 200 and 2) share
// one stimulus stream; directed table, corner sequences, then random traffic.
module tb_parking_occupancy_ctrl;

    localparam int CAP_B = 200;
    localparam int CAP_S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic entry_req = 1'b0;
    logic exit_req = 1'b0;

    logic       e_ack_b, e_grant_b, x_ack_b, full_b, empty_b, err_b;
    logic [7:0] cnt_b, free_b;
    logic       e_ack_s, e_grant_s, x_ack_s, full_s, empty_s, err_s;
    logic [7:0] cnt_s, free_s;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    parking_occupancy_ctrl #(.CAPACITY(8'd200)) dut_b (
        .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
        .entry_ack(e_ack_b), .entry_grant(e_grant_b), .exit_ack(x_ack_b),
        .count(cnt_b), .free(free_b), .full(full_b), .empty(empty_b),
        .err_underflow(err_b)
    );

    parking_occupancy_ctrl #(.CAPACITY(8'd2)) dut_s (
        .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
        .entry_ack(e_ack_s), .entry_grant(e_grant_s), .exit_ack(x_ack_s),
        .count(cnt_s), .free(free_s), .full(full_s), .empty(empty_s),
        .err_underflow(err_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        entry_req = 1'b0;
        exit_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One full handshake; returns ack latency in cycles (-1 on timeout).
    task automatic do_op(input bit is_exit, output int lat, output logic gb, output logic gs);
        lat = -1;
        gb = 1'b0;
        gs = 1'b0;
        if (is_exit) exit_req = 1'b1;
        else         entry_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (is_exit ? x_ack_b : e_ack_b) begin
                lat = c;
                gb = e_grant_b;
                gs = e_grant_s;
                break;
            end
        end
        if (is_exit) exit_req = 1'b0;
        else         entry_req = 1'b0;
        tick();
        tick();
    endtask

    // Status flags must track count every cycle; both instances see the same traffic.
    always @(negedge clk) begin
        if (mon_en) begin
            check("free_b_vs_count", free_b, CAP_B - int'(cnt_b));
            check("full_b_vs_count", full_b, (int'(cnt_b) == CAP_B));
            check("empty_b_vs_count", empty_b, (cnt_b == 8'd0));
            check("free_s_vs_count", free_s, CAP_S - int'(cnt_s));
            check("full_s_vs_count", full_s, (int'(cnt_s) == CAP_S));
            check("empty_s_vs_count", empty_s, (cnt_s == 8'd0));
            check("both_acks_same_cycle", e_ack_b & x_ack_b, 1'b0);
            check("ack_timing_s_vs_b", {e_ack_s, x_ack_s}, {e_ack_b, x_ack_b});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit is_exit;
        bit g_b;
        bit g_s;
        int cnt_b;
        int cnt_s;
        bit err_b;
        bit err_s;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int   lat, xl, el, mid, n_ack;
        logic gb, gs;
        int   m_cnt_b, m_cnt_s;
        bit   m_err_b, m_err_s;
        bit   wait_e, wait_x;
        int   hold_e, hold_x, low_e, low_x, age_e, age_x;

        //            exit gb gs cnt_b cnt_s err_b err_s
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 2, 2, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 3, 2, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 2, 1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1, 1, 1'b1, 1'b1};

        tick();
        tick();
        check("rst_async_count", cnt_b, 0);
        check("rst_async_free", free_b, CAP_B);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        check("rst_count", cnt_b, 0);
        check("rst_free_b", free_b, CAP_B);
        check("rst_free_s", free_s, CAP_S);
        check("rst_full", full_b, 0);
        check("rst_empty", empty_b, 1);
        check("rst_entry_ack", e_ack_b, 0);
        check("rst_entry_grant", e_grant_b, 0);
        check("rst_exit_ack", x_ack_b, 0);
        check("rst_err", err_b, 0);

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].is_exit, lat, gb, gs);
            check($sformatf("tbl%0d_latency", i), lat, 2);
            if (!tbl[i].is_exit) begin
                check($sformatf("tbl%0d_grant_b", i), gb, tbl[i].g_b);
                check($sformatf("tbl%0d_grant_s", i), gs, tbl[i].g_s);
            end
            check($sformatf("tbl%0d_count_b", i), cnt_b, tbl[i].cnt_b);
            check($sformatf("tbl%0d_count_s", i), cnt_s, tbl[i].cnt_s);
            check($sformatf("tbl%0d_free_b", i), free_b, CAP_B - tbl[i].cnt_b);
            check($sformatf("tbl%0d_full_s", i), full_s, (tbl[i].cnt_s == CAP_S));
            check($sformatf("tbl%0d_err_b", i), err_b, tbl[i].err_b);
            check($sformatf("tbl%0d_err_s", i), err_s, tbl[i].err_s);
        end

        // Simultaneous entry/exit at count 5: exit first, entry three cycles later.
        reset_dut();
        for (int i = 0; i < 5; i++) do_op(1'b0, lat, gb, gs);
        check("simul_start_count", cnt_b, 5);
        entry_req = 1'b1;
        exit_req = 1'b1;
        xl = -1;
        el = -1;
        mid = 999;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 3) mid = cnt_b;
            if (x_ack_b && xl < 0) begin
                xl = c;
                exit_req = 1'b0;
            end
            if (e_ack_b && el < 0) begin
                el = c;
                entry_req = 1'b0;
            end
            if (el > 0) break;
        end
        entry_req = 1'b0;
        exit_req = 1'b0;
        check("simul_exit_latency", xl, 2);
        check("simul_mid_count", mid, 4);
        check("simul_entry_latency", el, 5);
        tick();
        check("simul_final_count", cnt_b, 5);
        tick();

        // Entry held high long after its ack counts once.
        entry_req = 1'b1;
        n_ack = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (e_ack_b) n_ack++;
        end
        check("held_req_ack_count", n_ack, 1);
        check("held_req_count", cnt_b, 6);
        entry_req = 1'b0;
        tick();
        do_op(1'b0, lat, gb, gs);
        check("rearm_latency", lat, 2);
        check("rearm_count", cnt_b, 7);

        // Reset during COMPUTE with count 7: immediate clear, no ack.
        entry_req = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_rst_count", cnt_b, 0);
        check("midop_rst_free", free_b, CAP_B);
        check("midop_rst_empty", empty_b, 1);
        check("midop_rst_ack", e_ack_b, 0);
        entry_req = 1'b0;
        tick();
        rst_n = 1'b1;
        n_ack = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (e_ack_b || x_ack_b) n_ack++;
        end
        check("midop_rst_no_ack", n_ack, 0);
        check("midop_rst_count_after", cnt_b, 0);

        // Random traffic against an event-level occupancy model.
        reset_dut();
        m_cnt_b = 0; m_cnt_s = 0; m_err_b = 0; m_err_s = 0;
        wait_e = 0; wait_x = 0; hold_e = 0; hold_x = 0;
        low_e = 1; low_x = 1; age_e = 0; age_x = 0;
        for (int t = 0; t < 4000; t++) begin
            tick();
            check("rand_count_b", cnt_b, m_cnt_b);
            check("rand_count_s", cnt_s, m_cnt_s);
            check("rand_err_b", err_b, m_err_b);
            check("rand_err_s", err_s, m_err_s);

            if (e_ack_b) begin
                check("rand_entry_ack_pending", wait_e, 1'b1);
                check("rand_grant_b", e_grant_b, (m_cnt_b < CAP_B));
                check("rand_grant_s", e_grant_s, (m_cnt_s < CAP_S));
                if (m_cnt_b < CAP_B) m_cnt_b++;
                if (m_cnt_s < CAP_S) m_cnt_s++;
                wait_e = 0;
                hold_e = $urandom_range(0, 3);
            end
            if (x_ack_b) begin
                check("rand_exit_ack_pending", wait_x, 1'b1);
                if (m_cnt_b == 0) m_err_b = 1; else m_cnt_b--;
                if (m_cnt_s == 0) m_err_s = 1; else m_cnt_s--;
                wait_x = 0;
                hold_x = $urandom_range(0, 3);
            end

            if (wait_e) begin
                age_e++;
                if (age_e > 20) begin
                    check("rand_entry_ack_timeout", age_e, 20);
                    wait_e = 0;
                end
            end else if (entry_req) begin
                if (hold_e == 0) begin
                    entry_req = 1'b0;
                    low_e = $urandom_range(1, 4);
                end else hold_e--;
            end else if (low_e == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    entry_req = 1'b1;
                    wait_e = 1;
                    age_e = 0;
                end
            end else low_e--;

            if (wait_x) begin
                age_x++;
                if (age_x > 20) begin
                    check("rand_exit_ack_timeout", age_x, 20);
                    wait_x = 0;
                end
            end else if (exit_req) begin
                if (hold_x == 0) begin
                    exit_req = 1'b0;
                    low_x = $urandom_range(1, 4);
                end else hold_x--;
            end else if (low_x == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    exit_req = 1'b1;
                    wait_x = 1;
                    age_x = 0;
                end
            end else low_x--;
        end

        entry_req = 1'b0;
        exit_req = 1'b0;
        tick();
        tick();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
